mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Round-robin arbiter that shares one fixed-point `multiplier` instance (start/done/busy handshake, Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH) between NUM_REQ requesters.
- Typical requesters: decoder_LSTM gate MACs, output projection, encoder cell.
- Latches the winner's operands, drives the multiplier, returns the result with a one-cycle ack, and guards against a hung multiplier with a timeout.

Parameters:
- DATA_WIDTH, 32, operand/result width (signed).
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1000000, max cycles in WAIT before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- a_in  in  NUM_REQ x DATA_WIDTH  operand A per requester.
- b_in  in  NUM_REQ x DATA_WIDTH  operand B per requester.
- ack  out  NUM_REQ  one-hot, one-cycle pulse; result valid.
- result  out  DATA_WIDTH  product for the acked requester.
- grant_id  out  $clog2(NUM_REQ)  index of current/last winner.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky; set on multiplier timeout.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a, mul_b  out  DATA_WIDTH  latched operands to the multiplier.
- mul_result  in  DATA_WIDTH  multiplier product.
- mul_done  in  1  multiplier completion pulse.

Behaviour:
- Reset values: ack=0, result=0, grant_id=0, busy=0, timeout_err=0, mul_start=0, mul_a=mul_b=0, rr_ptr=0, state=IDLE, timeout counter=0.
- Reset mid-operation aborts with no ack. A multiplier still running is ignored: mul_done is only honoured in WAIT.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register grant_id, mul_a=a_in[g], mul_b=b_in[g]; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mul_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On mul_done: result<=mul_result, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES first: result<=0, timeout_err<=1, go to RESP.
  - If mul_done and timeout coincide, mul_done wins.
  - Counter clears on every WAIT exit.
- RESP:
  - ack[grant_id]=1 for this cycle only.
  - rr_ptr <= (grant_id+1) mod NUM_REQ; go to IDLE.
- Requester protocol:
  - Hold req and operands until ack is seen.
  - Drop req at the clock edge ending the ack cycle.
  - A req still high in the following IDLE cycle counts as a new request.
- Operands are sampled only in IDLE; later changes are ignored.
- Latency: req high in IDLE cycle c -> mul_start in c+1. If mul_done is high in cycle d, ack and result are valid in d+1.
- result holds its value until the next RESP.
- Fairness: with all requesters permanently requesting, grants strictly rotate. Max wait = (NUM_REQ-1) full transactions.
- req bits are combinationally ignored outside IDLE; no preemption.

Optional Feature:
- MUL_SHARE_ARBITER_STATS_EN defined:
  - Adds output port grant_count [NUM_REQ][16].
  - Each entry is a 16-bit saturating counter (sticks at 0xFFFF), incremented in RESP for grant_id.
  - Reset to 0.
  - A timed-out transaction still counts.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single request: req[2]=1, a=0x01800000 (1.5), b=0x02000000 (2.0), FRACT=24 multiplier -> one mul_start, ack=4'b0100 one cycle, result=0x03000000, grant_id=2, busy low after RESP.
- All four requests held from reset: each with a=0x01000000, b=k<<24 -> ack order 0,1,2,3, results 0x00000000/0x01000000/0x02000000/0x03000000, exactly one mul_start per grant.
- Fairness: req[0] and req[3] high continuously, re-asserted after each ack -> grants alternate 0,3,0,3.
- Timeout: stub multiplier never asserts done, TIMEOUT_CYCLES=16, req[1]=1 -> ack[1] after 16 WAIT cycles, result=0, timeout_err=1 and stays 1 through later good transactions.
- Reset mid-WAIT: assert rst while in WAIT -> all outputs at reset values immediately, no ack. A late mul_done after release is ignored, and a new req[0] is served normally.
- With MUL_SHARE_ARBITER_STATS_EN: run the all-four scenario twice -> grant_count = {2,2,2,2}.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter sharing one fixed-point multiplier between NUM_REQ requesters
// Optional per-requester grant counters are enabled with MUL_SHARE_ARBITER_STATS_EN.
module mul_share_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   a_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   b_in,
    output logic [NUM_REQ-1:0]              ack,
    output logic [DATA_WIDTH-1:0]           result,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            timeout_err,
    output logic                            mul_start,
    output logic [DATA_WIDTH-1:0]           mul_a,
    output logic [DATA_WIDTH-1:0]           mul_b,
    input  logic [DATA_WIDTH-1:0]           mul_result,
    input  logic                            mul_done
`ifdef MUL_SHARE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]           grant_count
`endif
);

    localparam int GW  = $clog2(NUM_REQ);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TMAX     = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]  LAST_ID  = GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [GW-1:0]  rr_ptr;
    logic [TCW-1:0] tcnt;
    logic [GW-1:0]  pick;
    logic           found;

    // First requesting index at or after rr_ptr, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            tcnt        <= '0;
            ack         <= '0;
            result      <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
        end else begin
            mul_start <= 1'b0;
            ack       <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id  <= pick;
                        mul_a     <= a_in[pick*DATA_WIDTH +: DATA_WIDTH];
                        mul_b     <= b_in[pick*DATA_WIDTH +: DATA_WIDTH];
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion in the same cycle as expiry is still a good result.
                    if (mul_done) begin
                        result <= mul_result;
                        ack    <= ONE << grant_id;
                        tcnt   <= '0;
                        state  <= RESP;
                    end else if (tcnt == TMAX) begin
                        result      <= '0;
                        timeout_err <= 1'b1;
                        ack         <= ONE << grant_id;
                        tcnt        <= '0;
                        state       <= RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUL_SHARE_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_count <= '0;
        end else if (state == RESP && grant_count[grant_id*16 +: 16] != 16'hFFFF) begin
            grant_count[grant_id*16 +: 16] <= grant_count[grant_id*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter with a Q8.24 multiplier stub
module tb_mul_share_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] a_in;
    logic [127:0] b_in;
    logic [3:0]   ack;
    logic [31:0]  result;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout_err;
    logic         mul_start;
    logic [31:0]  mul_a;
    logic [31:0]  mul_b;
    logic [31:0]  mul_result;
    logic         mul_done;
`ifdef MUL_SHARE_ARBITER_STATS_EN
    logic [63:0]  grant_count;
`endif

    mul_share_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .result(result), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .mul_start(mul_start), .mul_a(mul_a),
        .mul_b(mul_b), .mul_result(mul_result), .mul_done(mul_done)
`ifdef MUL_SHARE_ARBITER_STATS_EN
        , .grant_count(grant_count)
`endif
    );

    typedef struct {
        logic [3:0]  ack;
        logic [31:0] res;
        logic [1:0]  gid;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_starts = 0;
    int   mode     = 0;   // 0 normal (3 cycles), 1 never done, 2 done after 20 cycles
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Multiplier stub: Q8.24 signed product
    initial begin
        logic signed [63:0] p;
        mul_done   = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge clk);
            if (mul_start) begin
                n_starts++;
                if (mode != 1) begin
                    p = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
                    repeat ((mode == 2) ? 19 : 2) @(negedge clk);
                    mul_result = p[55:24];
                    mul_done   = 1'b1;
                    @(negedge clk);
                    mul_done   = 1'b0;
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        a_in[i*32 +: 32] = a;
        b_in[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        req  = '0;
        mode = 0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ack(input int limit, output logic ok, output logic [3:0] a_s,
                            output logic [31:0] r_s, output logic [1:0] g_s);
        ok = 1'b0; a_s = '0; r_s = '0; g_s = '0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (ack != 4'b0) begin
                ok = 1'b1; a_s = ack; r_s = result; g_s = grant_id;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        @(negedge clk);
        n_checks++;
        if ({ack, result, grant_id, busy, timeout_err, mul_start, mul_a, mul_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got ack=%b res=%h gid=%0d busy=%b terr=%b start=%b a=%h b=%h, expected all 0",
                     ack, result, grant_id, busy, timeout_err, mul_start, mul_a, mul_b);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, ack, mul_start} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b ack=%b start=%b, expected 0", busy, ack, mul_start);
        end
    endtask

    task automatic test_single();
        logic ok; logic [3:0] a_s; logic [31:0] r_s; logic [1:0] g_s; exp_t e; int s0;
        do_reset();
        s0 = n_starts;
        set_op(2, 32'h0180_0000, 32'h0200_0000);
        sb.push_back('{4'b0100, 32'h0300_0000, 2'd2});
        req[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mul_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start_latency: got mul_start=%b, expected 1", mul_start);
        end
        wait_ack(40, ok, a_s, r_s, g_s);
        req[2] = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!ok || a_s !== e.ack || r_s !== e.res || g_s !== e.gid) begin
            n_fail++;
            $display("FAIL single_ack: got ok=%b ack=%b res=%h gid=%0d, expected ack=%b res=%h gid=%0d",
                     ok, a_s, r_s, g_s, e.ack, e.res, e.gid);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ack !== 4'b0 || result !== 32'h0300_0000) begin
            n_fail++;
            $display("FAIL single_after_resp: got busy=%b ack=%b res=%h, expected 0 0000 03000000", busy, ack, result);
        end
        n_checks++;
        if (n_starts - s0 !== 1) begin
            n_fail++;
            $display("FAIL single_start_count: got %0d, expected 1", n_starts - s0);
        end
    endtask

    task automatic run_all_four(input string tag);
        logic ok; logic [3:0] a_s; logic [31:0] r_s; logic [1:0] g_s; exp_t e;
        for (int k = 0; k < 4; k++) begin
            set_op(k, 32'h0100_0000, 32'(k) << 24);
            sb.push_back('{4'b0001 << k, 32'(k) << 24, 2'(k)});
        end
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(40, ok, a_s, r_s, g_s);
            req = req & ~a_s;
            e = sb.pop_front();
            n_checks++;
            if (!ok || a_s !== e.ack || r_s !== e.res || g_s !== e.gid) begin
                n_fail++;
                $display("FAIL %s_grant%0d: got ok=%b ack=%b res=%h gid=%0d, expected ack=%b res=%h gid=%0d",
                         tag, k, ok, a_s, r_s, g_s, e.ack, e.res, e.gid);
            end
            if (!ok) req = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_four();
        int s0;
        do_reset();
        s0 = n_starts;
        run_all_four("all_four");
        n_checks++;
        if (n_starts - s0 !== 4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL all_four_starts: got starts=%0d busy=%b, expected 4 0", n_starts - s0, busy);
        end
    endtask

    task automatic test_fairness();
        logic ok; logic [3:0] a_s; logic [31:0] r_s; logic [1:0] g_s; exp_t e;
        do_reset();
        set_op(0, 32'h0200_0000, 32'h0300_0000);
        set_op(3, 32'hFF00_0000, 32'h0500_0000);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb.push_back('{4'b0001, 32'h0600_0000, 2'd0});
            else            sb.push_back('{4'b1000, 32'hFB00_0000, 2'd3});
        end
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            wait_ack(40, ok, a_s, r_s, g_s);
            e = sb.pop_front();
            n_checks++;
            if (!ok || a_s !== e.ack || r_s !== e.res || g_s !== e.gid) begin
                n_fail++;
                $display("FAIL fairness_grant%0d: got ok=%b ack=%b res=%h gid=%0d, expected ack=%b res=%h gid=%0d",
                         k, ok, a_s, r_s, g_s, e.ack, e.res, e.gid);
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic ok; logic [3:0] a_s; logic [31:0] r_s; logic [1:0] g_s; exp_t e; int cs; logic seen;
        do_reset();
        mode = 1;
        set_op(1, 32'h0100_0000, 32'h0700_0000);
        sb.push_back('{4'b0010, 32'h0, 2'd1});
        req[1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mul_start;
        end
        cs = cyc;
        wait_ack(40, ok, a_s, r_s, g_s);
        req[1] = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!seen || !ok || a_s !== e.ack || r_s !== e.res || cyc - cs !== 17) begin
            n_fail++;
            $display("FAIL timeout_ack: got start=%b ok=%b ack=%b res=%h delay=%0d, expected ack=%b res=%h delay=17",
                     seen, ok, a_s, r_s, cyc - cs, e.ack, e.res);
        end
        n_checks++;
        if (timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err_set: got %b, expected 1", timeout_err);
        end
        mode = 0;
        @(negedge clk);
        set_op(1, 32'h0100_0000, 32'h0100_0000);
        sb.push_back('{4'b0010, 32'h0100_0000, 2'd1});
        req[1] = 1'b1;
        wait_ack(40, ok, a_s, r_s, g_s);
        req[1] = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!ok || a_s !== e.ack || r_s !== e.res || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got ok=%b ack=%b res=%h terr=%b, expected ack=%b res=%h terr=1",
                     ok, a_s, r_s, timeout_err, e.ack, e.res);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        logic ok; logic [3:0] a_s; logic [31:0] r_s; logic [1:0] g_s; exp_t e; logic seen; int stray;
        mode = 2;
        set_op(0, 32'h0300_0000, 32'h0300_0000);
        req[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mul_start;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        n_checks++;
        if (!seen || {ack, result, grant_id, busy, timeout_err, mul_start, mul_a, mul_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got start_seen=%b ack=%b res=%h gid=%0d busy=%b terr=%b a=%h b=%h, expected 1 and all 0",
                     seen, ack, result, grant_id, busy, timeout_err, mul_a, mul_b);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack != 4'b0 || busy) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL late_done_ignored: got %0d active cycles, expected 0", stray);
        end
        mode = 0;
        set_op(0, 32'h0080_0000, 32'h0400_0000);
        sb.push_back('{4'b0001, 32'h0200_0000, 2'd0});
        req[0] = 1'b1;
        wait_ack(40, ok, a_s, r_s, g_s);
        req[0] = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (!ok || a_s !== e.ack || r_s !== e.res || g_s !== e.gid) begin
            n_fail++;
            $display("FAIL after_reset_serve: got ok=%b ack=%b res=%h gid=%0d, expected ack=%b res=%h gid=%0d",
                     ok, a_s, r_s, g_s, e.ack, e.res, e.gid);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef MUL_SHARE_ARBITER_STATS_EN
    task automatic test_stats();
        do_reset();
        n_checks++;
        if (grant_count !== 64'h0) begin
            n_fail++;
            $display("FAIL stats_reset: got %h, expected 0", grant_count);
        end
        run_all_four("stats_r0");
        run_all_four("stats_r1");
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (grant_count[k*16 +: 16] !== 16'd2) begin
                n_fail++;
                $display("FAIL stats_count%0d: got %0d, expected 2", k, grant_count[k*16 +: 16]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_timeout();
        test_reset_mid_wait();
`ifdef MUL_SHARE_ARBITER_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
